// File: rtl/mmio_csr_pkg.sv
// Shared types for the MMIO CSR bank: register indices, length codes, read-pipe stage
// and the subset of the CCI-P interface structs this block touches.
package mmio_csr_pkg;

    localparam int IDX_DFH          = 0;
    localparam int IDX_AFU_ID_L     = 1;
    localparam int IDX_AFU_ID_H     = 2;
    localparam int IDX_STAT_RD      = 5;
    localparam int IDX_STAT_WR      = 6;
    localparam int IDX_STAT_ERR     = 7;
    localparam int IDX_SCRATCH_BASE = 8;

    localparam logic [1:0] LEN_4B  = 2'd0;
    localparam logic [1:0] LEN_8B  = 2'd1;
    localparam logic [1:0] LEN_64B = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [8:0]  tid;
        logic [63:0] data;
    } t_mmio_rd_stage;

    // MMIO request header, addressed in 32-bit DWORDs
    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [511:0]        data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [27:0] hdr;
        logic        rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [73:0] hdr;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [79:0]  hdr;
        logic [511:0] data;
        logic         valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    // 4B reads return the selected DWORD in both halves of the response
    function automatic logic [63:0] pick_dword(input logic [63:0] value, input logic upper);
        return upper ? {value[63:32], value[63:32]} : {value[31:0], value[31:0]};
    endfunction

endpackage

// File: rtl/mmio_csr_bank_rd_pipe.sv
// Fixed-latency delay line for MMIO read responses; reset drops everything in flight.
module mmio_rd_pipe
    import mmio_csr_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  t_mmio_rd_stage in_stage,
    output t_mmio_rd_stage out_stage
);

    t_mmio_rd_stage stage_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage samples its
    // predecessor's pre-edge value; blocking here would collapse the pipe to one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_stage;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_stage = stage_q[DEPTH-1];

endmodule

// File: rtl/mmio_csr_bank.sv
// CCI-P MMIO CSR bank: read-only AFU header, optional statistics, read/write scratch.
// Define MMIO_CSR_STATS_EN to build the read/write/dropped-access counters at idx 5..7.
module mmio_csr_bank
    import mmio_csr_pkg::*;
#(
    parameter int          NUM_REGS   = 64,
    parameter int          RD_LATENCY = 2,
    parameter logic [63:0] DFH_VALUE  = 64'h1000_0000_0000_0000,
    parameter logic [63:0] AFU_ID_L   = 64'h0,
    parameter logic [63:0] AFU_ID_H   = 64'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  t_if_ccip_Rx              cp2af_sRxPort,
    output t_if_ccip_Tx              af2cp_sTxPort,
    output logic [NUM_REGS*64-1:0]   regs_q
);

    localparam int IDX_W = $clog2(NUM_REGS);

    t_ccip_c0_ReqMmioHdr hdr;
    logic                wr_valid;
    logic                rd_valid;
    logic [63:0]         wr_data;
    logic [IDX_W-1:0]    idx;
    logic                dword_hi;
    logic                out_of_range;
    logic                len_ok;
    logic                wr_en;
    logic                wr_drop;
    logic                rd_ok;

    assign hdr          = cp2af_sRxPort.c0.hdr;
    assign wr_valid     = cp2af_sRxPort.c0.mmioWrValid;
    assign rd_valid     = cp2af_sRxPort.c0.mmioRdValid;
    assign wr_data      = cp2af_sRxPort.c0.data[63:0];
    assign idx          = hdr.address[IDX_W:1];
    assign dword_hi     = hdr.address[0];
    assign out_of_range = |hdr.address[15:IDX_W+1];

    // 8B accesses must be QWORD aligned; 64B and the unused code are never legal
    assign len_ok  = (hdr.length == LEN_4B) || (hdr.length == LEN_8B && !dword_hi);
    assign rd_ok   = !out_of_range && len_ok;
    assign wr_en   = wr_valid && !out_of_range && len_ok && (idx >= IDX_W'(IDX_SCRATCH_BASE));
    assign wr_drop = wr_valid && !wr_en;

    logic [63:0] scratch_q [NUM_REGS];
    logic [63:0] reg_view  [NUM_REGS];

    // NOTE: this array is explicitly reset because the AFU consumes it through regs_q
    // and expects zeros; plain storage arrays would normally be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                scratch_q[i] <= '0;
            end
        end else if (wr_en) begin
            if (hdr.length == LEN_8B) begin
                scratch_q[idx] <= wr_data;
            end else if (dword_hi) begin
                scratch_q[idx][63:32] <= wr_data[31:0];
            end else begin
                scratch_q[idx][31:0] <= wr_data[31:0];
            end
        end
    end

`ifdef MMIO_CSR_STATS_EN
    logic [63:0] stat_rd_q;
    logic [63:0] stat_wr_q;
    logic [15:0] stat_err_q;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;

    assign err_inc = {1'b0, wr_drop} + {1'b0, rd_valid && hdr.length == LEN_64B};
    assign err_sum = {1'b0, stat_err_q} + 17'(err_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_q  <= '0;
            stat_wr_q  <= '0;
            stat_err_q <= '0;
        end else begin
            stat_rd_q  <= stat_rd_q + 64'(rd_valid);
            stat_wr_q  <= stat_wr_q + 64'(wr_valid);
            stat_err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`endif

    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path can leave it unassigned and infer a latch.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_view[i] = '0;
        end
        reg_view[IDX_DFH]      = DFH_VALUE;
        reg_view[IDX_AFU_ID_L] = AFU_ID_L;
        reg_view[IDX_AFU_ID_H] = AFU_ID_H;
`ifdef MMIO_CSR_STATS_EN
        reg_view[IDX_STAT_RD]  = stat_rd_q;
        reg_view[IDX_STAT_WR]  = stat_wr_q;
        reg_view[IDX_STAT_ERR] = {48'b0, stat_err_q};
`endif
        for (int i = IDX_SCRATCH_BASE; i < NUM_REGS; i++) begin
            reg_view[i] = scratch_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i*64 +: 64] = reg_view[i];
        end
    end

    // Read data is taken from pre-edge state, so a same-cycle write is not visible
    t_mmio_rd_stage rd_in;
    t_mmio_rd_stage rd_out;

    always_comb begin
        rd_in.valid = rd_valid;
        rd_in.tid   = hdr.tid;
        rd_in.data  = '0;
        if (rd_ok) begin
            rd_in.data = (hdr.length == LEN_4B) ? pick_dword(reg_view[idx], dword_hi)
                                                : reg_view[idx];
        end
    end

    mmio_rd_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_stage  (rd_in),
        .out_stage (rd_out)
    );

    always_comb begin
        af2cp_sTxPort                = '0;
        af2cp_sTxPort.c2.hdr.tid     = rd_out.tid;
        af2cp_sTxPort.c2.mmioRdValid = rd_out.valid;
        af2cp_sTxPort.c2.data        = rd_out.data;
    end

    logic unused_rx;
    assign unused_rx = ^{cp2af_sRxPort.c0TxAlmFull, cp2af_sRxPort.c1TxAlmFull,
                         cp2af_sRxPort.c0.rspValid, cp2af_sRxPort.c0.data[511:64],
                         hdr.rsvd, cp2af_sRxPort.c1};

endmodule

// File: tb/tb_mmio_csr_bank.sv
// Self-checking bench for mmio_csr_bank: directed scenarios plus random traffic
// scored against a register-map model indexed by plain DWORD-address arithmetic.
module tb_mmio_csr_bank;
    import mmio_csr_pkg::*;

    localparam int          NUM_REGS   = 64;
    localparam int          RD_LATENCY = 2;
    localparam logic [63:0] DFH        = 64'h1000_0000_0000_0000;
    localparam logic [63:0] AFU_L      = 64'hA5A5_0000_1111_2222;
    localparam logic [63:0] AFU_H      = 64'h5A5A_3333_4444_5555;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    t_if_ccip_Rx            rx  = '0;
    t_if_ccip_Tx            tx;
    logic [NUM_REGS*64-1:0] regs_q;

    mmio_csr_bank #(
        .NUM_REGS   (NUM_REGS),
        .RD_LATENCY (RD_LATENCY),
        .DFH_VALUE  (DFH),
        .AFU_ID_L   (AFU_L),
        .AFU_ID_H   (AFU_H)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cp2af_sRxPort (rx),
        .af2cp_sTxPort (tx),
        .regs_q        (regs_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [8:0]  tid;
        logic [63:0] data;
    } resp_t;

    resp_t exp_q[$];
    resp_t obs_q[$];
    resp_t last_obs[$];

    always @(negedge clk) begin
        if (tx.c2.mmioRdValid === 1'b1)
            obs_q.push_back('{cyc: cyc, tid: tx.c2.hdr.tid, data: tx.c2.data});
    end

    // ---------------- reference model ----------------
    logic [63:0]     m_mem [NUM_REGS];
    longint unsigned m_rd_cnt;
    longint unsigned m_wr_cnt;
    int              m_err;

    task automatic m_reset();
        for (int i = 0; i < NUM_REGS; i++) m_mem[i] = '0;
        m_rd_cnt = 0;
        m_wr_cnt = 0;
        m_err    = 0;
    endtask

    function automatic logic [63:0] m_view(input int idx);
        if (idx == 0) return DFH;
        if (idx == 1) return AFU_L;
        if (idx == 2) return AFU_H;
`ifdef MMIO_CSR_STATS_EN
        if (idx == 5) return m_rd_cnt;
        if (idx == 6) return m_wr_cnt;
        if (idx == 7) return 64'(m_err);
`endif
        if (idx >= 8 && idx < NUM_REGS) return m_mem[idx];
        return 64'h0;
    endfunction

    function automatic logic [63:0] m_read(input int addr, input int len);
        int          idx;
        logic [63:0] v;
        logic [31:0] dw;
        idx = addr / 2;
        if (addr >= 2 * NUM_REGS) return 64'h0;
        if (len == 0) begin
            v  = m_view(idx);
            dw = (addr % 2 == 1) ? v[63:32] : v[31:0];
            return {dw, dw};
        end
        if (len == 1 && addr % 2 == 0) return m_view(idx);
        return 64'h0;
    endfunction

    function automatic bit m_write(input int addr, input int len, input logic [63:0] d);
        int idx;
        idx = addr / 2;
        if (addr >= 2 * NUM_REGS || idx < 8) return 1'b0;
        if (len == 1 && addr % 2 == 0) begin
            m_mem[idx] = d;
            return 1'b1;
        end
        if (len == 0) begin
            if (addr % 2 == 1) m_mem[idx][63:32] = d[31:0];
            else               m_mem[idx][31:0]  = d[31:0];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input bit wr, input bit rd, input int addr, input int len,
                        input logic [8:0] tid, input logic [63:0] data);
        int drops;
        @(posedge clk);
        #1;
        rx                    = '0;
        rx.c0.hdr.address     = 16'(addr);
        rx.c0.hdr.length      = 2'(len);
        rx.c0.hdr.tid         = tid;
        rx.c0.data[63:0]      = data;
        rx.c0.data[511:448]   = {$urandom(), $urandom()};
        rx.c0.mmioWrValid     = wr;
        rx.c0.mmioRdValid     = rd;
        drops = 0;
        if (rd) begin
            exp_q.push_back('{cyc: cyc + RD_LATENCY, tid: tid, data: m_read(addr, len)});
            m_rd_cnt++;
            if (len == 2) drops++;
        end
        if (wr) begin
            m_wr_cnt++;
            if (!m_write(addr, len, data)) drops++;
        end
        m_err = (m_err + drops > 65535) ? 65535 : m_err + drops;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rx = '0;
        end
    endtask

    task automatic drain(input string name);
        int budget;
        int n;
        budget = 0;
        while (obs_q.size() < exp_q.size() && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        repeat (RD_LATENCY + 3) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s count got %0d responses expected %0d", name, obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[i].tid !== exp_q[i].tid) begin
                errors++;
                $display("FAIL %s[%0d] tid got %h expected %h", name, i, obs_q[i].tid, exp_q[i].tid);
            end
            checks++;
            if (obs_q[i].data !== exp_q[i].data) begin
                errors++;
                $display("FAIL %s[%0d] data got %h expected %h", name, i, obs_q[i].data, exp_q[i].data);
            end
            checks++;
            if (obs_q[i].cyc !== exp_q[i].cyc) begin
                errors++;
                $display("FAIL %s[%0d] cycle got %0d expected %0d", name, i, obs_q[i].cyc, exp_q[i].cyc);
            end
        end
        last_obs = obs_q;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_last(input string name, input int i, input logic [63:0] expv);
        checks++;
        if (i >= last_obs.size()) begin
            errors++;
            $display("FAIL %s response %0d missing", name, i);
        end else if (last_obs[i].data !== expv) begin
            errors++;
            $display("FAIL %s data got %h expected %h", name, last_obs[i].data, expv);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        rx  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (tx !== '0) begin
            errors++;
            $display("FAIL reset_tx got %h expected 0", tx.c2);
        end
        checks++;
        if (regs_q[63:0] !== DFH) begin
            errors++;
            $display("FAIL reset_dfh got %h expected %h", regs_q[63:0], DFH);
        end
        checks++;
        if (regs_q[8*64-1:3*64] !== '0) begin
            errors++;
            $display("FAIL reset_idx3_7 got %h expected 0", regs_q[8*64-1:3*64]);
        end
        checks++;
        if (regs_q[NUM_REGS*64-1:8*64] !== '0) begin
            errors++;
            $display("FAIL reset_scratch got nonzero expected 0");
        end
    endtask

    task automatic test_dfh_read();
        send(0, 1, 0, 1, 9'h05, 64'h0);
        idle(1);
        drain("dfh_read");
        check_last("dfh_value", 0, DFH);
    endtask

    task automatic test_partial_write();
        send(1, 0, 16, 1, 9'h0, 64'hDEAD_BEEF_CAFE_F00D);
        send(1, 0, 17, 0, 9'h0, 64'h0000_0000_1234_5678);
        send(0, 1, 16, 1, 9'h10, 64'h0);
        send(0, 1, 16, 0, 9'h11, 64'h0);
        idle(1);
        drain("partial_write");
        check_last("merged_8b", 0, 64'h1234_5678_CAFE_F00D);
        check_last("dword_4b", 1, 64'hCAFE_F00D_CAFE_F00D);
    endtask

    task automatic test_illegal_writes();
        send(1, 0, 0, 1, 9'h0, 64'h1);
        send(1, 0, 2 * NUM_REGS, 1, 9'h0, 64'h1);
        send(1, 0, 19, 1, 9'h0, 64'h1);
        send(0, 1, 0, 1, 9'h20, 64'h0);
        send(0, 1, 2 * NUM_REGS, 1, 9'h21, 64'h0);
        send(0, 1, 18, 1, 9'h22, 64'h0);
        send(0, 1, 14, 1, 9'h23, 64'h0);
        idle(1);
        drain("illegal_writes");
        check_last("ro_dfh", 0, DFH);
        check_last("oor_read", 1, 64'h0);
        check_last("odd_8b_unchanged", 2, 64'h0);
`ifdef MMIO_CSR_STATS_EN
        check_last("drop_count", 3, 64'd3);
`else
        check_last("stats_absent", 3, 64'd0);
`endif
    endtask

    task automatic test_back_to_back();
        send(0, 1, 2, 1, 9'h1, 64'h0);
        send(0, 1, 4, 1, 9'h2, 64'h0);
        send(0, 1, 16, 1, 9'h3, 64'h0);
        idle(1);
        drain("back_to_back");
        check_last("b2b_afu_l", 0, AFU_L);
        check_last("b2b_afu_h", 1, AFU_H);
        check_last("b2b_scratch", 2, 64'h1234_5678_CAFE_F00D);
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (i >= last_obs.size() || last_obs[i].cyc !== last_obs[i-1].cyc + 1) begin
                errors++;
                $display("FAIL b2b_consecutive[%0d] responses not in adjacent cycles", i);
            end
        end
    endtask

    task automatic test_same_cycle();
        send(1, 0, 18, 1, 9'h0, 64'h55);
        send(1, 1, 18, 1, 9'h7, 64'hAA);
        send(0, 1, 18, 1, 9'h8, 64'h0);
        idle(1);
        drain("same_cycle");
        check_last("same_cycle_old", 0, 64'h55);
        check_last("next_cycle_new", 1, 64'hAA);
    endtask

    task automatic test_random();
        logic [NUM_REGS*64-1:0] exp_flat;
        for (int n = 0; n < 400; n++) begin
            int  addr;
            int  len;
            bit  wr;
            bit  rd;
            logic [31:0] r;
            r    = $urandom();
            addr = (r[3:0] == 4'hF) ? int'(r[31:16]) : int'($urandom_range(0, 2 * NUM_REGS + 7));
            len  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
            wr   = ($urandom_range(0, 2) != 0);
            rd   = ($urandom_range(0, 2) != 0);
            send(wr, rd, addr, len, 9'($urandom()), {$urandom(), $urandom()});
        end
        idle(1);
        drain("random");
        for (int i = 0; i < NUM_REGS; i++) exp_flat[i*64 +: 64] = m_view(i);
        checks++;
        if (regs_q !== exp_flat) begin
            errors++;
            $display("FAIL random_regs_q got %h expected %h", regs_q[16*64-1:0], exp_flat[16*64-1:0]);
        end
    endtask

    task automatic test_reset_mid();
        resp_t keep[$];
        int    c;
        send(1, 0, 16, 1, 9'h0, 64'hFFFF_0000_1234_0000);
        send(0, 1, 16, 1, 9'h1AB, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx  = '0;
        c   = cyc;
        foreach (exp_q[i]) if (exp_q[i].cyc <= c) keep.push_back(exp_q[i]);
        exp_q = keep;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        idle(8);
        drain("reset_inflight");
        send(0, 1, 16, 1, 9'h30, 64'h0);
        send(0, 1, 18, 1, 9'h31, 64'h0);
        idle(1);
        drain("after_reset");
        check_last("scratch16_zero", 0, 64'h0);
        check_last("scratch18_zero", 1, 64'h0);
    endtask

    initial begin
        test_reset();
        test_dfh_read();
        test_partial_write();
        test_illegal_writes();
        test_back_to_back();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
